// File: rtl/subsys_apb_master.sv
// Single-outstanding APB master bridge: valid/ready command in, APB SETUP/ACCESS out, valid/ready response back.
// Optional ACCESS-phase timeout enabled by defining SUBSYS_APB_TIMEOUT_EN.
module subsys_apb_master #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic [DATA_WIDTH-1:0] PWDATA,
   output logic                  PWRITE,
   output logic                  PSEL,
   output logic                  PENABLE,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PREADY,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t state;
   logic   unused_bits;

`ifdef SUBSYS_APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] tmo_cnt;
   logic             err_q;

   assign rsp_err     = err_q;
   assign unused_bits = ^cmd_addr[1:0];
`else
   assign rsp_err     = 1'b0;
   assign unused_bits = ^{cmd_addr[1:0], (TIMEOUT_CYCLES != 0)};
`endif

   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   // NOTE: all state and registered outputs use non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state     <= IDLE;
         PADDR     <= '0;
         PWDATA    <= '0;
         PWRITE    <= 1'b0;
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
`ifdef SUBSYS_APB_TIMEOUT_EN
         tmo_cnt   <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  // Address is word-aligned; the byte offset is dropped.
                  PADDR  <= {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
                  PWDATA <= cmd_wdata;
                  PWRITE <= cmd_write;
                  PSEL   <= 1'b1;
                  state  <= SETUP;
               end
            end
            SETUP: begin
               PENABLE <= 1'b1;
               state   <= ACCESS;
`ifdef SUBSYS_APB_TIMEOUT_EN
               tmo_cnt <= '0;
`endif
            end
            ACCESS: begin
               if (PREADY) begin
                  rsp_rdata <= PWRITE ? '0 : PRDATA;
                  rsp_valid <= 1'b1;
                  PSEL      <= 1'b0;
                  PENABLE   <= 1'b0;
                  state     <= RESP;
`ifdef SUBSYS_APB_TIMEOUT_EN
                  err_q     <= 1'b0;
               end else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
                  rsp_rdata <= '0;
                  err_q     <= 1'b1;
                  rsp_valid <= 1'b1;
                  PSEL      <= 1'b0;
                  PENABLE   <= 1'b0;
                  state     <= RESP;
               end else begin
                  tmo_cnt   <= tmo_cnt + 1'b1;
`endif
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_subsys_apb_master.sv
// Scoreboard bench for subsys_apb_master: random commands vs. a word-addressed memory model,
// with an APB slave model, protocol monitor and response monitor.
module tb_subsys_apb_master;

   localparam int AW = 32;
   localparam int DW = 32;
`ifdef SUBSYS_APB_TIMEOUT_EN
   localparam int LONG_WAITS = 3;
`else
   localparam int LONG_WAITS = 5;
`endif

   logic          PCLK = 1'b0;
   logic          PRESET = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic [AW-1:0] PADDR;
   logic [DW-1:0] PWDATA;
   logic          PWRITE;
   logic          PSEL;
   logic          PENABLE;
   logic [DW-1:0] PRDATA = '0;
   logic          PREADY = 1'b0;
   logic          busy;

   subsys_apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
      .PRDATA(PRDATA), .PREADY(PREADY), .busy(busy)
   );

   always #5 PCLK = ~PCLK;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Power-on contents shared by the slave and the reference model.
   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a == 32'h0000_000C) ? 32'h0000_DEAD : (32'hA5A5_0000 | a);
   endfunction

   // ---------------- APB slave model ----------------
   logic [31:0] slv_mem [logic [31:0]];
   int          wait_cfg = 0;   // <0: random 0..3 wait states per access
   bit          stuck = 1'b0;
   int          waits_left = 0;

   always @(negedge PCLK) begin
      if (PSEL && !PENABLE)
         waits_left = (wait_cfg < 0) ? int'($urandom_range(0, 3)) : wait_cfg;
      if (PSEL && PENABLE) begin
         PREADY = !stuck && (waits_left == 0);
         if (waits_left > 0) waits_left--;
         PRDATA = PWRITE ? $urandom : (slv_mem.exists(PADDR) ? slv_mem[PADDR] : init_word(PADDR));
      end else begin
         PREADY = 1'b0;
         PRDATA = $urandom;
      end
   end

   always @(posedge PCLK)
      if (!PRESET && PSEL && PENABLE && PREADY && PWRITE) slv_mem[PADDR] = PWDATA;

   // ---------------- protocol monitor ----------------
   logic        prev_sel = 1'b0, prev_en = 1'b0;
   logic [31:0] prev_addr = '0;
   logic [31:0] setup_addr = '0;
   int          acc_len = 0, last_acc_len = 0;

   always @(negedge PCLK) begin
      if (PRESET) begin
         prev_sel = 1'b0;
         prev_en  = 1'b0;
         acc_len  = 0;
      end else begin
         if (prev_sel && !prev_en) check("setup_then_access", {62'd0, PSEL, PENABLE}, 64'd3);
         if (PSEL && !PENABLE) begin
            check("setup_after_idle", prev_sel, 0);
            check("paddr_aligned", PADDR[1:0], 0);
            setup_addr = PADDR;
            acc_len    = 0;
         end else if (PSEL && PENABLE) begin
            check("paddr_stable", PADDR, prev_addr);
            acc_len++;
         end else if (prev_sel && prev_en) begin
            last_acc_len = acc_len;
         end
         prev_sel  = PSEL;
         prev_en   = PENABLE;
         prev_addr = PADDR;
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   rsp_t        sb[$];
   logic [31:0] ref_mem [logic [31:0]];
   bit          rdy_force = 1'b1;

   always @(posedge PCLK) begin
      #2;
      rsp_ready = rdy_force ? 1'b1 : ($urandom_range(0, 9) < 7);
   end

   always @(negedge PCLK) begin
      if (!PRESET && rsp_valid && rsp_ready) begin
         check("rsp_expected", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            rsp_t e;
            e = sb.pop_front();
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_err", rsp_err, e.err);
         end
      end
   end

   function automatic logic [31:0] model_read(input logic [31:0] a);
      logic [31:0] wa;
      wa = a & ~32'h3;
      return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
   endfunction

   time accept_t = 0;

   task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, input bit tmo);
      int   guard = 0;
      rsp_t e;
      @(negedge PCLK);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      while (!cmd_ready && guard < 300) begin
         @(negedge PCLK);
         guard++;
      end
      if (!cmd_ready) begin
         check("cmd_accept_timeout", guard, 0);
         cmd_valid = 1'b0;
         return;
      end
      accept_t = $time;
      if (tmo) begin
         e.rdata = '0;
         e.err   = 1'b1;
      end else if (w) begin
         ref_mem[a & ~32'h3] = d;
         e.rdata = '0;
         e.err   = 1'b0;
      end else begin
         e.rdata = model_read(a);
         e.err   = 1'b0;
      end
      sb.push_back(e);
      @(posedge PCLK);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int g = 0;
      while ((sb.size() != 0 || busy) && g < 400) begin
         @(negedge PCLK);
         g++;
      end
      check("drain_queue_empty", sb.size(), 0);
   endtask

   initial begin
      time t_prev;
      int  g;

      // Reset state
      repeat (3) @(negedge PCLK);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_psel", PSEL, 0);
      check("rst_penable", PENABLE, 0);
      check("rst_pwrite", PWRITE, 0);
      check("rst_paddr", PADDR, 0);
      check("rst_pwdata", PWDATA, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_busy", busy, 0);
      PRESET = 1'b0;

      // Write then read back, zero-wait
      send(1'b1, 32'h0, 32'h0000_0003, 1'b0);
      send(1'b0, 32'h0, 32'h0, 1'b0);
      drain();

      // Preloaded word; one SETUP and one ACCESS cycle
      send(1'b0, 32'hC, 32'h0, 1'b0);
      drain();
      check("zero_wait_access_len", last_acc_len, 1);

      // Misaligned address and back-to-back throughput
      send(1'b0, 32'hA, 32'h0, 1'b0);
      drain();
      check("misaligned_paddr", setup_addr, 32'h8);
      send(1'b0, 32'h4, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         t_prev = accept_t;
         send(1'b1, 32'h10 + 32'(i * 4), $urandom, 1'b0);
         check("b2b_accept_period", accept_t - t_prev, 40);
      end
      drain();

      // Long ACCESS with wait states
      wait_cfg = LONG_WAITS;
      send(1'b0, 32'h10, 32'h0, 1'b0);
      drain();
      check("wait_access_len", last_acc_len, LONG_WAITS + 1);
      wait_cfg = 0;

`ifdef SUBSYS_APB_TIMEOUT_EN
      stuck = 1'b1;
      send(1'b0, 32'h20, 32'h0, 1'b1);
      drain();
      check("timeout_access_len", last_acc_len, 5);
      stuck = 1'b0;
      send(1'b0, 32'h20, 32'h0, 1'b0);
      drain();
`endif

      // Reset during ACCESS
      stuck = 1'b1;
      send(1'b0, 32'h14, 32'h0, 1'b0);
      g = 0;
      while (!(PSEL && PENABLE) && g < 20) begin
         @(negedge PCLK);
         g++;
      end
      check("reach_access", {62'd0, PSEL, PENABLE}, 64'd3);
      #2 PRESET = 1'b1;
      #1;
      check("async_rst_psel", PSEL, 0);
      check("async_rst_penable", PENABLE, 0);
      @(posedge PCLK);
      #1 check("rst_no_rsp", rsp_valid, 0);
      sb.delete();
      @(negedge PCLK);
      PRESET = 1'b0;
      stuck  = 1'b0;
      check("post_rst_cmd_ready", cmd_ready, 1);
      repeat (3) begin
         @(negedge PCLK);
         check("post_rst_no_rsp", rsp_valid, 0);
      end
      send(1'b1, 32'h8, 32'h5, 1'b0);
      send(1'b0, 32'h8, 32'h0, 1'b0);
      drain();
      check("paddr_holds_idle", PADDR, 32'h8);

      // Randomised traffic with wait states and response backpressure
      wait_cfg  = -1;
      rdy_force = 1'b0;
      for (int i = 0; i < 60; i++)
         send(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom, 1'b0);
      drain();
      rdy_force = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
